// File: rtl/z80_intc.sv
// z80_intc: Z80 mode-2 vectored interrupt controller answering the M1+IORQ acknowledge.
// Optional feature macro INTC_RETI_SNOOP_EN enables in-service masking and RETI retirement.
module z80_intc #(
  parameter int unsigned NUM_SRC  = 4,
  parameter logic [7:0]  VEC_BASE = 8'h40
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               nM1,
  input  logic               nIORQ,
  input  logic               nMREQ,
  input  logic               nRD,
  input  logic [7:0]         D_in,
  output logic [7:0]         D_out,
  output logic               D_oe,
  output logic               nINT
);

  localparam int unsigned IDX_W        = 3;
  localparam logic [7:0]  SPURIOUS_VEC = 8'hFF;

  if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
    $error("z80_intc: NUM_SRC must be in 1..8");
  end

  typedef enum logic {IDLE, ACK} ack_state_t;

  ack_state_t         ack_state;
  ack_state_t         ack_state_nxt;
  logic [NUM_SRC-1:0] irq_req_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic               any_eligible;
  logic [IDX_W-1:0]   winner_idx;
  logic               ack;
  logic [7:0]         d_out_nxt;
  logic               d_oe_nxt;

  // Previous request level for edge detection; sampled through reset so a
  // request held high across reset release does not look like a new edge.
  always_ff @(posedge CLK) begin
    irq_req_q <= irq_req;
  end

  assign rise = irq_req & ~irq_req_q;
  assign ack  = ~nM1 & ~nIORQ;

  // A new edge outranks the acknowledge clear on the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~grant) | rise;
    end
  end

  assign any_eligible = |eligible;

  always_comb begin
    winner_idx = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) winner_idx = IDX_W'(i);
    end
  end

  // Acknowledge FSM: state register
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      ack_state <= IDLE;
    end else begin
      ack_state <= ack_state_nxt;
    end
  end

  // Acknowledge FSM: next state
  always_comb begin
    ack_state_nxt = ack_state;
    case (ack_state)
      IDLE:    if (ack)  ack_state_nxt = ACK;
      ACK:     if (!ack) ack_state_nxt = IDLE;
      default: ack_state_nxt = IDLE;
    endcase
  end

  // Acknowledge FSM: vector, bus enable and grant for the winning source
  always_comb begin
    d_out_nxt = D_out;
    d_oe_nxt  = D_oe;
    grant     = '0;
    case (ack_state)
      IDLE: begin
        if (ack) begin
          d_oe_nxt = 1'b1;
          if (any_eligible) begin
            d_out_nxt = {VEC_BASE[7:4], winner_idx, 1'b0};
            grant     = NUM_SRC'(1) << winner_idx;
          end else begin
            d_out_nxt = SPURIOUS_VEC;
          end
        end
      end
      ACK: begin
        if (!ack) d_oe_nxt = 1'b0;
      end
      default: d_oe_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      D_out <= 8'h00;
      D_oe  <= 1'b0;
      nINT  <= 1'b1;
    end else begin
      D_out <= d_out_nxt;
      D_oe  <= d_oe_nxt;
      nINT  <= ~any_eligible;
    end
  end

`ifdef INTC_RETI_SNOOP_EN
  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_4D = 8'h4D;

  typedef enum logic {R_IDLE, R_ED} reti_state_t;

  reti_state_t        reti_state;
  reti_state_t        reti_state_nxt;
  logic               fetch_active_q;
  logic [7:0]         fetch_byte_q;
  logic               fetch_done;
  logic               reti_hit;
  logic [NUM_SRC-1:0] in_service_q;
  logic [NUM_SRC-1:0] lowest_isr;
  logic [NUM_SRC-1:0] retire;

  // Opcode byte is the bus value on the last M1+MREQ+RD cycle before RD rises.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      fetch_active_q <= 1'b0;
      fetch_byte_q   <= 8'h00;
    end else if (!nM1 && !nMREQ && !nRD) begin
      fetch_active_q <= 1'b1;
      fetch_byte_q   <= D_in;
    end else if (nRD) begin
      fetch_active_q <= 1'b0;
    end
  end

  assign fetch_done = fetch_active_q & nRD;

  // RETI FSM: state register
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      reti_state <= R_IDLE;
    end else begin
      reti_state <= reti_state_nxt;
    end
  end

  // RETI FSM: next state
  always_comb begin
    reti_state_nxt = reti_state;
    case (reti_state)
      R_IDLE:  if (fetch_done && fetch_byte_q == OP_ED) reti_state_nxt = R_ED;
      R_ED:    if (fetch_done) reti_state_nxt = R_IDLE;
      default: reti_state_nxt = R_IDLE;
    endcase
  end

  // RETI FSM: retire strobe on ED,4D
  always_comb begin
    reti_hit = 1'b0;
    case (reti_state)
      R_ED:    reti_hit = fetch_done && (fetch_byte_q == OP_4D);
      default: reti_hit = 1'b0;
    endcase
  end

  always_comb begin
    lowest_isr = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (in_service_q[i]) begin
        lowest_isr    = '0;
        lowest_isr[i] = 1'b1;
      end
    end
  end

  assign retire = reti_hit ? lowest_isr : '0;

  // Retire is applied before the new grant on a shared edge.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      in_service_q <= '0;
    end else begin
      in_service_q <= (in_service_q & ~retire) | grant;
    end
  end

  // A source is masked by any in-service source of equal or higher priority.
  always_comb begin
    logic blocked;
    blocked  = 1'b0;
    eligible = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      blocked     = blocked | in_service_q[i];
      eligible[i] = pending_q[i] & ~blocked;
    end
  end
`else
  logic unused_snoop_inputs;

  assign eligible            = pending_q;
  assign unused_snoop_inputs = ^{nMREQ, nRD, D_in};
`endif

endmodule

// File: tb/tb_z80_intc.sv
// tb_z80_intc: vector table, directed corner sequences and random traffic against a reference model.
// Honours INTC_RETI_SNOOP_EN the same way as the design.
module tb_z80_intc;

  localparam int unsigned N  = 4;
  localparam logic [7:0]  VB = 8'h40;
`ifdef INTC_RETI_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         nRESET;
  logic [N-1:0] irq_req;
  logic         nM1, nIORQ, nMREQ, nRD;
  logic [7:0]   D_in;
  logic [7:0]   D_out;
  logic         D_oe;
  logic         nINT;

  always #5 CLK = ~CLK;

  z80_intc #(.NUM_SRC(N), .VEC_BASE(VB)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .irq_req(irq_req),
    .nM1    (nM1),
    .nIORQ  (nIORQ),
    .nMREQ  (nMREQ),
    .nRD    (nRD),
    .D_in   (D_in),
    .D_out  (D_out),
    .D_oe   (D_oe),
    .nINT   (nINT)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_pend, m_isvc, m_prev;
  logic         m_nint, m_doe, m_in_ack, m_saw_ed, m_fpend;
  logic [7:0]   m_dout, m_fbyte;

  typedef struct {
    logic [N-1:0] irq;
    logic         nm1, niorq, nmreq, nrd;
    logic [7:0]   din;
    logic         nrst;
    logic         exp_nint, exp_doe;
    logic [7:0]   exp_dout;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, from the inputs now on the pins.
  task automatic model_edge();
    logic [N-1:0] pend_n, isvc_n;
    logic any_e;
    int   w, seen, k;
    pend_n = m_pend;
    isvc_n = m_isvc;
    if (!nRESET) begin
      pend_n = '0; isvc_n = '0;
      m_nint = 1'b1; m_doe = 1'b0; m_dout = 8'h00;
      m_in_ack = 1'b0; m_saw_ed = 1'b0; m_fpend = 1'b0;
    end else begin
      any_e = 1'b0; w = 0; seen = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (SNOOP && m_isvc[i]) seen++;
        if (!any_e && m_pend[i] && seen == 0) begin any_e = 1'b1; w = i; end
      end
      m_nint = !any_e;
      if (!m_in_ack && !nM1 && !nIORQ) begin
        m_in_ack = 1'b1;
        m_doe    = 1'b1;
        if (any_e) begin
          m_dout    = (VB & 8'hF0) | 8'(2 * w);
          pend_n[w] = 1'b0;
          if (SNOOP) isvc_n[w] = 1'b1;
        end else begin
          m_dout = 8'hFF;
        end
      end else if (m_in_ack && !(!nM1 && !nIORQ)) begin
        m_in_ack = 1'b0;
        m_doe    = 1'b0;
      end
      if (m_fpend && nRD) begin
        if (!m_saw_ed) begin
          m_saw_ed = (m_fbyte == 8'hED);
        end else begin
          m_saw_ed = 1'b0;
          if (SNOOP && m_fbyte == 8'h4D) begin
            k = -1;
            for (int i = 0; i < int'(N); i++) if (k < 0 && m_isvc[i]) k = i;
            if (k >= 0) isvc_n[k] = 1'b0;
          end
        end
      end
      if (!nM1 && !nMREQ && !nRD) begin
        m_fpend = 1'b1;
        m_fbyte = D_in;
      end else if (nRD) begin
        m_fpend = 1'b0;
      end
      pend_n = pend_n | (irq_req & ~m_prev);
    end
    m_prev = irq_req;
    m_pend = pend_n;
    m_isvc = isvc_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    check("model_nint", {7'd0, nINT}, {7'd0, m_nint});
    check("model_doe",  {7'd0, D_oe}, {7'd0, m_doe});
    check("model_dout", D_out, m_dout);
  endtask

  task automatic bus_idle();
    nM1 = 1'b1; nIORQ = 1'b1; nMREQ = 1'b1; nRD = 1'b1;
  endtask

  task automatic bus_ack();
    nM1 = 1'b0; nIORQ = 1'b0; nMREQ = 1'b1; nRD = 1'b1;
  endtask

  task automatic fetch(input logic [7:0] b);
    nM1 = 1'b0; nIORQ = 1'b1; nMREQ = 1'b0; nRD = 1'b0; D_in = b;
    tick();
    bus_idle();
    tick();
  endtask

  task automatic pulse(input logic [N-1:0] r);
    irq_req = r;
    tick();
    irq_req = '0;
    tick();
  endtask

  task automatic do_reset();
    nRESET = 1'b0; irq_req = '0; bus_idle();
    repeat (3) tick();
    nRESET = 1'b1;
    tick();
  endtask

  initial begin
    m_pend = '0; m_isvc = '0; m_prev = '0;
    m_nint = 1'b1; m_doe = 1'b0; m_dout = 8'h00;
    m_in_ack = 1'b0; m_saw_ed = 1'b0; m_fpend = 1'b0; m_fbyte = 8'h00;
    nRESET = 1'b0; irq_req = '0; D_in = 8'h00; bus_idle();

    // irq, nM1, nIORQ, nMREQ, nRD, D_in, nRESET, nINT, D_oe, D_out
    tbl[0]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[9]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
    tbl[10] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
    tbl[11] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44};
    tbl[12] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44};

    // Reset and single request
    for (int r = 0; r < 13; r++) begin
      irq_req = tbl[r].irq; nM1 = tbl[r].nm1; nIORQ = tbl[r].niorq;
      nMREQ = tbl[r].nmreq; nRD = tbl[r].nrd; D_in = tbl[r].din; nRESET = tbl[r].nrst;
      tick();
      check($sformatf("tbl%0d_nint", r), {7'd0, nINT}, {7'd0, tbl[r].exp_nint});
      check($sformatf("tbl%0d_doe", r),  {7'd0, D_oe}, {7'd0, tbl[r].exp_doe});
      check($sformatf("tbl%0d_dout", r), D_out, tbl[r].exp_dout);
    end

    // Priority: sources 3 and 1 together
    do_reset();
    pulse(4'b1010);
    check("prio_nint", {7'd0, nINT}, 8'h00);
    bus_ack(); tick();
    check("prio_vec1", D_out, 8'h42);
    check("prio_doe", {7'd0, D_oe}, 8'h01);
    tick(); bus_idle(); tick();
    check("prio_doe_off", {7'd0, D_oe}, 8'h00);
`ifdef INTC_RETI_SNOOP_EN
    check("prio_masked", {7'd0, nINT}, 8'h01);
    fetch(8'hED); fetch(8'h4D); tick();
`endif
    check("prio_nint2", {7'd0, nINT}, 8'h00);
    bus_ack(); tick();
    check("prio_vec2", D_out, 8'h46);
    tick(); bus_idle(); tick();

`ifdef INTC_RETI_SNOOP_EN
    // Nesting
    do_reset();
    pulse(4'b0100);
    bus_ack(); tick();
    check("nest_vec2", D_out, 8'h44);
    tick(); bus_idle(); tick();
    pulse(4'b1000); tick();
    check("nest_blocked3", {7'd0, nINT}, 8'h01);
    pulse(4'b0001);
    check("nest_nint0", {7'd0, nINT}, 8'h00);
    bus_ack(); tick();
    check("nest_vec0", D_out, 8'h40);
    bus_idle(); tick();
    fetch(8'hED); fetch(8'h4D); tick();
    check("nest_still_blocked", {7'd0, nINT}, 8'h01);
    fetch(8'hED); fetch(8'h4D); tick();
    check("nest_src3_live", {7'd0, nINT}, 8'h00);
    bus_ack(); tick();
    check("nest_vec3", D_out, 8'h46);
    bus_idle(); tick();

    // RETN and non-M1 read must not retire
    do_reset();
    pulse(4'b0100);
    bus_ack(); tick(); bus_idle(); tick();
    pulse(4'b1000);
    fetch(8'hED); fetch(8'h45); tick();
    check("retn_no_clear", {7'd0, nINT}, 8'h01);
    fetch(8'hED);
    nM1 = 1'b1; nMREQ = 1'b0; nRD = 1'b0; D_in = 8'h4D; tick();
    bus_idle(); tick(); tick();
    check("nonm1_no_clear", {7'd0, nINT}, 8'h01);
    fetch(8'h00);
    fetch(8'hED); fetch(8'h4D); tick();
    check("reti_clear", {7'd0, nINT}, 8'h00);
`endif

    // Spurious acknowledge, then reset while acknowledging
    do_reset();
    bus_ack(); tick();
    check("spurious_vec", D_out, 8'hFF);
    nRESET = 1'b0; tick();
    check("rst_in_ack_doe", {7'd0, D_oe}, 8'h00);
    check("rst_in_ack_dout", D_out, 8'h00);
    bus_idle(); nRESET = 1'b1; tick();

    // New edge on the acknowledge edge of the same source
    do_reset();
    pulse(4'b0010);
    irq_req = 4'b0010; bus_ack(); tick();
    check("coll_vec", D_out, 8'h42);
    irq_req = '0; tick(); bus_idle(); tick();
`ifdef INTC_RETI_SNOOP_EN
    check("coll_masked", {7'd0, nINT}, 8'h01);
    fetch(8'hED); fetch(8'h4D); tick();
`endif
    check("coll_pending", {7'd0, nINT}, 8'h00);
    bus_ack(); tick();
    check("coll_vec2", D_out, 8'h42);
    bus_idle(); tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int unsigned op, sel;
      nRESET = ($urandom_range(299) != 0);
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(7) == 0) irq_req[i] = ~irq_req[i];
      op  = $urandom_range(7);
      sel = $urandom_range(3);
      case (sel)
        0: D_in = 8'hED;
        1: D_in = 8'h4D;
        2: D_in = 8'h45;
        default: D_in = 8'($urandom);
      endcase
      if (op < 2) bus_ack();
      else if (op < 5) begin nM1 = 1'b0; nIORQ = 1'b1; nMREQ = 1'b0; nRD = 1'b0; end
      else if (op == 5) begin nM1 = 1'b1; nIORQ = 1'b1; nMREQ = 1'b0; nRD = 1'b0; end
      else bus_idle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_intc.md
# z80_intc

Mode-2 vectored interrupt controller for the Z80 bus. It sits on the CPU pins as the target of the interrupt-acknowledge cycle: it collects up to NUM_SRC peripheral requests, drives nINT, and answers the M1+IORQ acknowledge with an 8-bit vector on the data bus. It snoops opcode fetches for RETI to retire the in-service source. This gives priority nesting without daisy-chain wiring.

## Interface

Parameters:

- NUM_SRC, 4: number of request sources, 1..8; index 0 is highest priority.
- VEC_BASE, 8'h40: vector base; low bits are replaced by the source index.

Ports:

- CLK  in  1  CPU clock; all logic on its rising edge.
- nRESET  in  1  synchronous, active-low reset.
- irq_req  in  NUM_SRC  per-source request, synchronous to CLK, rising-edge sensitive.
- nM1  in  1  CPU M1 strobe, active low.
- nIORQ  in  1  CPU IORQ strobe, active low.
- nMREQ  in  1  CPU MREQ strobe, active low.
- nRD  in  1  CPU RD strobe, active low.
- D_in  in  8  data bus as seen by the block.
- D_out  out  8  vector driven during acknowledge.
- D_oe  out  1  tri-state enable for D_out; the top level gates the bus with it.
- nINT  out  1  interrupt request to the CPU, active low, registered.

## Operation

- **Reset** (nRESET=0 at a CLK edge):
  - pending and in_service clear to 0.
  - nINT=1, D_oe=0, D_out=8'h00.
  - Acknowledge FSM goes to IDLE; RETI FSM goes to R_IDLE.
- **Request capture:** rise(i) = irq_req[i] & ~irq_req_q[i]. rise(i) sets pending[i].
- **Request masking:** a source is eligible if pending[i]=1 and no in_service[j] is set for j<=i.
- **nINT:** next nINT = ~(any eligible).
- **Acknowledge FSM:**
  - States: IDLE, ACK.
  - ack = ~nM1 & ~nIORQ.
  - IDLE→ACK when ack is sampled 1.
    - Winner = lowest-index eligible source.
    - D_out = VEC_BASE with bits [3:1] replaced by the winner index; bit 0 forced to 0.
    - D_oe=1.
    - pending[winner] clears; in_service[winner] sets.
  - No eligible source at acknowledge (spurious): D_out=8'hFF, no state change.
  - ACK→IDLE when ack is sampled 0: D_oe=0; D_out holds its value.
- **RETI snoop FSM:**
  - States: R_IDLE, R_ED.
  - A fetch byte is D_in registered on the last cycle where nM1, nMREQ and nRD were all 0, taken when nRD is next sampled 1.
  - R_IDLE→R_ED on fetch byte 8'hED.
  - R_ED→R_IDLE on any fetch byte. If that byte is 8'h4D, clear the lowest-index set in_service bit; if none is set, no-op.
  - An ack cycle does not affect the RETI FSM.
- **Simultaneous events:**
  - rise(i) on the same edge that acknowledge clears pending[i]: the set wins, and pending[i] stays 1.
  - RETI clear and acknowledge set on the same edge: the clear applies first, then the set.
- **Bit width:** NUM_SRC>8 is illegal. Elaboration-time $error.

## Timing

- irq_req[i] sampled 0 at edge k-1 and 1 at edge k:
  - pending[i]=1 after edge k.
  - nINT=0 after edge k+1.
- Acknowledge:
  - ack first sampled 1 at edge a: D_oe=1 and D_out valid after edge a; nINT=1 after edge a+1, unless another source is still eligible.
  - D_oe stays 1 while ack is sampled 1. D_oe=0 after the first edge where ack is sampled 0.
- RETI: in_service clears on the edge where nRD is sampled 1 after the 4D fetch. nINT may reassert one edge later.
- **Reset mid-operation:** nRESET=0 during ACK drops D_oe at that edge; there is no bus contention after reset.

## Configuration

- INTC_RETI_SNOOP_EN defined:
  - in_service masking and the RETI FSM are as above.
- INTC_RETI_SNOOP_EN undefined:
  - The RETI FSM and in_service are removed; eligible = pending.
  - Acknowledge clears only pending[winner]; nMREQ, nRD and D_in are unused.

## Test plan

- **Reset:** hold nRESET=0 for 3 CLKs with irq_req=4'b1111 → nINT=1, D_oe=0, D_out=8'h00; no pending survives the release of nRESET.
- **Single request:** pulse irq_req[2], then ack (nM1=0, nIORQ=0) for 3 CLKs → nINT=0 two edges after the rise; D_out=8'h44 and D_oe=1 for the ack window; nINT=1 afterwards.
- **Priority:** raise irq_req[3] and irq_req[1] on the same edge, then ack → vector 8'h42. A second ack, after RETI when snooping is enabled, gives 8'h46.
- **Nesting** (snoop on):
  - Service source 2 (no RETI), then raise irq_req[3] → nINT stays 1.
  - Raise irq_req[0] → nINT=0; ack gives 8'h40.
  - Fetch ED,4D → in_service[0] clears.
  - A second ED,4D clears in_service[2]; nINT then goes 0 for source 3.
- **Spurious and collision:**
  - Ack with nothing pending → D_out=8'hFF.
  - rise(1) on the same edge as the ack of source 1 → pending[1] remains 1.
- **Non-RETI:** fetch ED,45 (RETN) or ED then a non-M1 read of 4D → in_service unchanged.
